// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_fetch_pkg;
  localparam int XLEN = 64;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2,
    HALT = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset value, redirect load, or sequential increment.
module fetch_pc_reg
  import rv_fetch_pkg::*;
#(
  parameter int              W        = 64,
  parameter logic [W-1:0]    RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_pc_i,
  input  logic         inc_i,
  output logic [W-1:0] pc_o
);
  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  // Redirect wins over increment; the add wraps naturally at 2^W.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem request, a single holding register toward
// the decoder, and redirect handling that squashes wrong-path fetches.
module instr_fetch #(
  parameter int                             XLEN     = rv_fetch_pkg::XLEN,
  parameter logic [rv_fetch_pkg::XLEN-1:0]  RESET_PC = rv_fetch_pkg::DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misalign,
  output logic [1:0]      dbg_state_o
);
  import rv_fetch_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready and holds its payload until then.
  fetch_state_e    state_q;
  logic            drop_q;
  logic            if_valid_q;
  logic            misalign_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] ifpc_q;
  logic [XLEN-1:0] pc;
  logic            redir_ok;
  logic            redir_bad;
  logic            pc_inc;

  assign redir_ok  = redirect_valid && (state_q != HALT) && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (state_q != HALT) && (redirect_pc[1:0] != 2'b00);
  assign pc_inc    = (state_q == WAIT) && imem_resp_valid && !drop_q && !redirect_valid;

  fetch_pc_reg #(
    .W        (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load_i    (redir_ok),
    .load_pc_i (redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      instr_q    <= '0;
      ifpc_q     <= '0;
    end else if (redir_bad) begin
      // Misaligned target: stop fetching; any outstanding response is ignored.
      misalign_q <= 1'b1;
      if_valid_q <= 1'b0;
      drop_q     <= 1'b0;
      state_q    <= HALT;
    end else begin
      unique case (state_q)
        REQ: begin
          if (imem_req_ready) begin
            state_q <= WAIT;
            drop_q  <= redir_ok;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            drop_q <= 1'b0;
            if (drop_q || redir_ok) begin
              state_q <= REQ;
            end else begin
              instr_q    <= imem_resp_data;
              ifpc_q     <= pc;
              if_valid_q <= 1'b1;
              state_q    <= FULL;
            end
          end else if (redir_ok) begin
            drop_q <= 1'b1;
          end
        end
        FULL: begin
          if (redir_ok || if_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= REQ;
          end
        end
        HALT: begin
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc;
  assign if_valid       = if_valid_q;
  assign if_instr       = instr_q;
  assign if_pc          = ifpc_q;
  assign fetch_misalign = misalign_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: instance 0 uses RESET_PC=0, instance 1 uses
// RESET_PC=all-ones-3 to exercise PC wrap and reset during an outstanding fetch.
module tb_instr_fetch;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_ready [2];
  logic        if_ready  [2];
  logic        redir_v   [2];
  logic [63:0] redir_pc  [2];

  logic        req_valid [2];
  logic [63:0] req_addr  [2];
  logic        if_valid  [2];
  logic [31:0] if_instr  [2];
  logic [63:0] if_pc     [2];
  logic        misalign  [2];
  logic [1:0]  dbg_state [2];

  int mem_lat = 1;
  int n_vec   = 0;
  int n_err   = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BD1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data  = '0;
    int          pend_cnt   = 0;
    logic [63:0] pend_addr  = '0;
    logic        acc;
    logic        rst_now;
    logic [63:0] acc_addr;

    instr_fetch #(
      .XLEN     (64),
      .RESET_PC ((g == 0) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFC)
    ) u_dut (
      .clk             (clk),
      .rst             (rst[g]),
      .imem_req_valid  (req_valid[g]),
      .imem_req_ready  (req_ready[g]),
      .imem_req_addr   (req_addr[g]),
      .imem_resp_valid (resp_valid),
      .imem_resp_data  (resp_data),
      .if_valid        (if_valid[g]),
      .if_ready        (if_ready[g]),
      .if_instr        (if_instr[g]),
      .if_pc           (if_pc[g]),
      .redirect_valid  (redir_v[g]),
      .redirect_pc     (redir_pc[g]),
      .fetch_misalign  (misalign[g]),
      .dbg_state_o     (dbg_state[g])
    );

    // Memory model: responds mem_lat cycles after accepting a request; reset
    // alongside the fetch stage.
    always @(posedge clk) begin
      rst_now  = rst[g];
      acc      = req_valid[g] && req_ready[g] && !rst[g];
      acc_addr = req_addr[g];
      #1;
      resp_valid = 1'b0;
      if (rst_now) begin
        pend_cnt = 0;
      end else begin
        if (acc) begin
          pend_cnt  = mem_lat;
          pend_addr = acc_addr;
        end
        if (pend_cnt > 0) begin
          pend_cnt = pend_cnt - 1;
          if (pend_cnt == 0) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(pend_addr);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_req(input int d, input string tag, input logic v, input logic [63:0] a);
    check({tag, ".req_valid"}, 64'(req_valid[d]), 64'(v));
    if (v) check({tag, ".req_addr"}, req_addr[d], a);
  endtask

  task automatic chk_if(input int d, input string tag, input logic v, input logic [63:0] pc);
    check({tag, ".if_valid"}, 64'(if_valid[d]), 64'(v));
    if (v) begin
      check({tag, ".if_pc"}, if_pc[d], pc);
      check({tag, ".if_instr"}, 64'(if_instr[d]), 64'(mem_word(pc)));
    end
  endtask

  // One full REQ -> WAIT -> FULL -> REQ pass with a 1-cycle memory.
  task automatic fetch_one(input int d, input string tag, input logic [63:0] a);
    chk_req(d, {tag, ".req"}, 1'b1, a);
    chk_if(d, {tag, ".req"}, 1'b0, '0);
    tick();
    chk_req(d, {tag, ".wait"}, 1'b0, '0);
    chk_if(d, {tag, ".wait"}, 1'b0, '0);
    tick();
    chk_req(d, {tag, ".full"}, 1'b0, '0);
    chk_if(d, {tag, ".full"}, 1'b1, a);
    tick();
  endtask

  initial begin
    rst       = '{1'b1, 1'b1};
    req_ready = '{1'b1, 1'b1};
    if_ready  = '{1'b1, 1'b1};
    redir_v   = '{1'b0, 1'b0};
    redir_pc  = '{64'h0, 64'h0};

    // Reset state
    tick();
    tick();
    chk_if(0, "rst", 1'b0, '0);
    check("rst.if_pc", if_pc[0], 64'h0);
    check("rst.if_instr", 64'(if_instr[0]), 64'h0);
    check("rst.misalign", 64'(misalign[0]), 64'h0);
    rst[0] = 1'b0;

    // 1: sequential fetch, one instruction every 3 cycles
    for (int k = 0; k < 4; k++) fetch_one(0, "seq", 64'(4 * k));

    // 2: decoder stall holds outputs and blocks new requests
    if_ready[0] = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_if(0, "stall", 1'b1, 64'h10);
      chk_req(0, "stall", 1'b0, '0);
      tick();
    end
    if_ready[0] = 1'b1;
    tick();
    chk_if(0, "stall.rel", 1'b0, '0);

    // 3: redirect in WAIT with slow memory drops the wrong-path word
    chk_req(0, "rw.req", 1'b1, 64'h14);
    mem_lat = 3;
    tick();
    redir_v[0]  = 1'b1;
    redir_pc[0] = 64'h100;
    tick();
    redir_v[0] = 1'b0;
    chk_req(0, "rw.w1", 1'b0, '0);
    chk_if(0, "rw.w1", 1'b0, '0);
    tick();
    chk_if(0, "rw.w2", 1'b0, '0);
    tick();
    chk_if(0, "rw.drop", 1'b0, '0);
    mem_lat = 1;
    fetch_one(0, "rw.new", 64'h100);

    // 4: redirect in FULL with a simultaneous handshake
    fetch_one(0, "pre4", 64'h104);
    chk_req(0, "rf.req", 1'b1, 64'h108);
    tick();
    tick();
    chk_if(0, "rf.full", 1'b1, 64'h108);
    redir_v[0]  = 1'b1;
    redir_pc[0] = 64'h200;
    tick();
    redir_v[0] = 1'b0;
    chk_if(0, "rf.after", 1'b0, '0);
    fetch_one(0, "rf.new", 64'h200);

    // 5: misaligned redirect halts; reset restarts
    chk_req(0, "mis.req", 1'b1, 64'h204);
    redir_v[0]  = 1'b1;
    redir_pc[0] = 64'h102;
    tick();
    redir_v[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("mis.flag", 64'(misalign[0]), 64'h1);
      chk_req(0, "mis.halt", 1'b0, '0);
      chk_if(0, "mis.halt", 1'b0, '0);
      tick();
    end
    redir_v[0]  = 1'b1;
    redir_pc[0] = 64'h300;
    tick();
    redir_v[0] = 1'b0;
    chk_req(0, "halt.redir", 1'b0, '0);
    tick();
    chk_req(0, "halt.redir2", 1'b0, '0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("mis.clr", 64'(misalign[0]), 64'h0);
    fetch_one(0, "mis.restart", 64'h0);

    // 6: PC wrap and reset while a fetch is outstanding
    rst[1] = 1'b0;
    fetch_one(1, "wrap.first", 64'hFFFF_FFFF_FFFF_FFFC);
    chk_req(1, "wrap.second", 1'b1, 64'h0);
    tick();
    chk_req(1, "wrap.wait", 1'b0, '0);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk_if(1, "rstwait", 1'b0, '0);
    fetch_one(1, "rstwait.restart", 64'hFFFF_FFFF_FFFF_FFFC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
